uart_rx_fifo: RTL and testbench

Memory-mapped 8N1 UART receiver with a receive FIFO and a level interrupt, attached as a slave on the picorv32 native memory bus next to the RAM and SPI flash controller. The top-level address decoder gates `valid`. This block's `ready`/`rdata` join the SoC `mem_ready` OR and `mem_rdata` mux, and `irq` drives one CPU interrupt line. It is the serial-input stage that feeds received bytes to software.

---
 rtl/uart_rx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a receive FIFO and level interrupt, attached as a
// slave on the picorv32 native memory bus.
module uart_rx_fifo #(
    parameter int DEPTH       = 8,
    parameter int DEFAULT_DIV = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_n;
    logic        rx_s1, rx_s2;
    logic [15:0] cnt, cnt_n, div, div_wr;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shreg, shreg_n;
    logic        push, ferr_set;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [8:0]    count;
    logic          overrun, frame_err, irq_en;

    logic        acc, is_rd, wr, pop, full, not_empty, push_ok;
    logic [1:0]  sel;
    logic [31:0] rd_mux;
    logic        unused;

    assign acc       = valid & ~ready;
    assign sel       = addr[3:2];
    assign is_rd     = (wstrb == 4'b0000);
    assign wr        = acc & ~is_rd;
    assign not_empty = (count != 9'd0);
    assign full      = (count == 9'(DEPTH));
    assign pop       = acc & is_rd & (sel == 2'd0) & not_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push & (~full | pop);
    assign unused    = ^{addr[31:4], addr[1:0], wdata[31:16], count[8]};

    // ---- rx synchronizer
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // ---- receiver FSM
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push      = 1'b0;
        ferr_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s2) begin
                    cnt_n   = div >> 1;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    if (!rx_s2) begin
                        cnt_n     = div - 16'd1;
                        bit_idx_n = 3'd0;
                        state_n   = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    shreg_n   = {rx_s2, shreg[7:1]};
                    cnt_n     = div - 16'd1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    state_n  = IDLE;
                    push     = rx_s2;
                    ferr_set = ~rx_s2;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
        end
    end

    always_ff @(posedge clk) shreg <= shreg_n;

    // ---- receive FIFO
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wp] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (push_ok && !pop)
                count <= count + 9'd1;
            else if (pop && !push_ok)
                count <= count - 9'd1;
        end
    end

    // ---- bus registers
    always_comb begin
        div_wr = div;
        if (wstrb[0])
            div_wr[7:0] = wdata[7:0];
        if (wstrb[1])
            div_wr[15:8] = wdata[15:8];
        if (div_wr < 16'd4)
            div_wr = 16'd4;
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            2'd0:    if (not_empty) rd_mux = {23'b0, 1'b1, mem[rp]};
            2'd1:    rd_mux = {16'b0, count[7:0], 4'b0, frame_err, overrun, full, not_empty};
            2'd2:    rd_mux = {16'b0, div};
            default: rd_mux = {31'b0, irq_en};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= 16'(DEFAULT_DIV);
            irq_en    <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            irq       <= 1'b0;
            ready     <= 1'b0;
            rdata     <= '0;
        end else begin
            if (wr && sel == 2'd2 && (wstrb[1:0] != 2'b00))
                div <= div_wr;
            if (wr && sel == 2'd3 && wstrb[0])
                irq_en <= wdata[0];
            overrun   <= (overrun & ~(wr && sel == 2'd1 && wstrb[0] && wdata[2]))
                         | (push & ~push_ok);
            frame_err <= (frame_err & ~(wr && sel == 2'd1 && wstrb[0] && wdata[3]))
                         | ferr_set;
            irq       <= irq_en & (not_empty | overrun | frame_err);
            ready     <= acc;
            rdata     <= (acc && is_rd) ? rd_mux : 32'd0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo against a queue-based model of
// the receiver, its FIFO, sticky flags and bus registers.
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;
    localparam int DDIV  = 104;

    logic        clk = 1'b0, reset = 1'b1, valid = 1'b0, rx = 1'b1;
    logic [3:0]  wstrb = 4'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, irq;
    logic [31:0] rdata;

    uart_rx_fifo #(.DEPTH(DEPTH), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .reset(reset), .valid(valid), .ready(ready), .wstrb(wstrb),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rx(rx), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic [31:0] expq[$];

    // reference model
    logic [7:0] mq[$];
    bit m_ovr = 0, m_fe = 0, m_ien = 0;
    int m_div = DDIV;
    int e0 = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // monitor: every ready pulse consumes one scoreboard entry
    bit prev_ready = 0;
    always @(negedge clk) begin
        if (ready) begin
            chk("ready_single_cycle", {31'b0, prev_ready}, 32'd0);
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ready: rdata %h with no pending access", rdata);
            end else begin
                chk("rdata", rdata, expq.pop_front());
            end
        end else begin
            chk("rdata_idle", rdata, 32'd0);
        end
        prev_ready = ready;
    end

    function automatic logic [31:0] model_status();
        int n = mq.size();
        return 32'(n * 256 + (m_fe ? 8 : 0) + (m_ovr ? 4 : 0) + (n == DEPTH ? 2 : 0) + (n != 0 ? 1 : 0));
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0: begin
                if (mq.size() > 0) return 32'h100 + 32'(mq.pop_front());
                return 32'd0;
            end
            2'd1:    return model_status();
            2'd2:    return 32'(m_div);
            default: return {31'b0, m_ien};
        endcase
    endfunction

    function automatic void model_write(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        int lo, hi;
        if (a == 2'd1 && s[0]) begin
            if (d[2]) m_ovr = 0;
            if (d[3]) m_fe = 0;
        end
        if (a == 2'd2 && (s[0] || s[1])) begin
            lo = s[0] ? int'(d[7:0]) : m_div % 256;
            hi = s[1] ? int'(d[15:8]) : m_div / 256;
            m_div = hi * 256 + lo;
            if (m_div < 4) m_div = 4;
        end
        if (a == 2'd3 && s[0]) m_ien = d[0];
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok)              m_fe = 1;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else                       m_ovr = 1;
    endfunction

    // bus access; caller is positioned at a negedge
    task automatic bus(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        bit seen = 0;
        addr = {28'b0, a, 2'b00}; wstrb = s; wdata = d; valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready) begin seen = 1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL bus_timeout: no ready for addr %0d", a);
        end
        valid = 1'b0; wstrb = 4'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        expq.push_back(model_read(a));
        bus(a, 4'b0000, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        expq.push_back(32'd0);
        model_write(a, s, d);
        bus(a, s, d);
    endtask

    task automatic check_irq(input string nm);
        chk(nm, {31'b0, irq}, {31'b0, m_ien && (mq.size() > 0 || m_ovr || m_fe)});
    endtask

    // drive one 8N1 frame; abort_at > 0 pulses reset at that bit-cycle instead
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int abort_at);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10 * m_div; i++) begin
            @(negedge clk);
            if (i == 0) e0 = cyc + 1;
            if (abort_at > 0 && i == abort_at) begin
                reset = 1'b1; rx = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                mq.delete(); m_ovr = 0; m_fe = 0; m_ien = 0; m_div = DDIV;
                repeat (3) @(negedge clk);
                return;
            end
            rx = bits[i / m_div];
        end
        @(negedge clk);
        rx = 1'b1;
        repeat (m_div + 4) @(negedge clk);
        model_frame(b, stop_ok);
    endtask

    initial begin
        int target;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("ready_after_reset", {31'b0, ready}, 32'd0);
        check_irq("irq_after_reset");
        rd(2'd1); rd(2'd2); rd(2'd3); rd(2'd0);

        // divider programming and clamping
        wr(2'd2, 4'b0011, 32'd1);      rd(2'd2);
        wr(2'd2, 4'b0010, 32'h0300);   rd(2'd2);
        wr(2'd2, 4'b0011, 32'd16);     rd(2'd2);

        // single frame
        send_frame(8'hA5, 1, 0);
        rd(2'd0); rd(2'd1);

        // start-bit glitch
        @(negedge clk); rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (2 * m_div) @(negedge clk);
        rd(2'd1);

        // overflow: nine frames, no reads
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1, 0);
        rd(2'd1);
        for (int i = 0; i < 9; i++) rd(2'd0);
        wr(2'd1, 4'b0001, 32'h4); rd(2'd1);

        // framing error and interrupt
        send_frame(8'h55, 0, 0);
        rd(2'd1);
        wr(2'd3, 4'b0001, 32'd1);
        @(negedge clk); @(negedge clk);
        check_irq("irq_frame_err");
        wr(2'd1, 4'b0001, 32'h8);
        @(negedge clk);
        check_irq("irq_after_w1c");
        rd(2'd1);

        // full FIFO: pop lands on the same edge as the stop-bit push
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1, 0);
        e0 = -1;
        fork
            send_frame(8'h3C, 1, 0);
            begin
                for (int k = 0; k < 5000; k++) begin
                    @(negedge clk);
                    if (e0 >= 0) begin
                        target = e0 + 3 + m_div / 2 + 9 * m_div - 1;
                        if (cyc == target) break;
                    end
                end
                rd(2'd0);
            end
        join
        rd(2'd1);
        for (int i = 0; i < DEPTH; i++) rd(2'd0);
        rd(2'd1);

        // randomized traffic
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: wr(2'd2, 4'b0011, 32'd8);
                    1: wr(2'd2, 4'b0011, 32'd12);
                    2: wr(2'd2, 4'b0011, 32'd21);
                    default: wr(2'd2, 4'b0011, 32'd16);
                endcase
            end
            b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 5) != 0, 0);
            check_irq("irq_random");
            for (int r = $urandom_range(0, 2); r > 0; r--) rd(2'd0);
            if ($urandom_range(0, 2) == 0) rd(2'd1);
            if ($urandom_range(0, 4) == 0) wr(2'd1, 4'b0001, 32'hC);
        end
        rd(2'd1);
        while (mq.size() > 0) rd(2'd0);
        wr(2'd1, 4'b0001, 32'hC);
        wr(2'd2, 4'b0011, 32'd16);

        // reset during data bit 4, then a full frame at the default divider
        send_frame(8'h99, 1, 5 * m_div + m_div / 2);
        rd(2'd1); rd(2'd2); rd(2'd3);
        check_irq("irq_after_midframe_reset");
        send_frame(8'h6B, 1, 0);
        rd(2'd0); rd(2'd1);

        for (int k = 0; k < 20 && expq.size() > 0; k++) @(negedge clk);
        if (expq.size() > 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: %0d responses never arrived", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
